// File: rtl/maze_pkg.sv
// ============================================================================
//  Module      : maze_pkg
//  Description : Shared types and constants for the maze game blocks.
//                Holds the player-controller state encoding, the screen
//                geometry and the default respawn / teleport coordinates.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package maze_pkg;

  // Player controller states, 2-bit explicit encoding
  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_DEAD = 2'd1,
    ST_WIN  = 2'd2,
    ST_OVER = 2'd3
  } state_t;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;

  localparam int START_X_DEF  = 8;
  localparam int START_Y_DEF  = 7;
  localparam int TP_DST_X_DEF = 424;
  localparam int TP_DST_Y_DEF = 97;

endpackage : maze_pkg

`default_nettype wire

// File: rtl/pos_axis.sv
// ============================================================================
//  Module      : pos_axis
//  Description : One-axis step-and-clamp. Produces the next floor coordinate
//                of the player block from the current one.
//  Ports       : i_flr   current floor coordinate
//                i_inc   step toward the limit
//                i_dec   step toward zero (wins over i_inc)
//                i_limit largest legal floor coordinate
//                o_flr   next floor coordinate
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module pos_axis #(
  parameter int STEP = 4
) (
  input  logic [9:0] i_flr,
  input  logic       i_inc,
  input  logic       i_dec,
  input  logic [9:0] i_limit,
  output logic [9:0] o_flr
);

  // Sum is formed in 11 bits so a step past 1023 cannot wrap below the limit
  logic [10:0] w_sum;
  assign w_sum = {1'b0, i_flr} + 11'(STEP);

  always_comb begin
    o_flr = i_flr;
    if (i_dec) begin
      o_flr = (i_flr < 10'(STEP)) ? 10'd0 : (i_flr - 10'(STEP));
    end else if (i_inc) begin
      o_flr = (w_sum > {1'b0, i_limit}) ? i_limit : w_sum[9:0];
    end
  end

endmodule : pos_axis

`default_nettype wire

// File: rtl/player_ctrl.sv
// ============================================================================
//  Module      : player_ctrl
//  Description : Player-block controller. Holds the block position, steps it
//                on frame ticks and reacts to region flags (goal, lava,
//                teleport) with win, death/respawn, lives and game-over.
//  Ports       : clk, reset            clock, synchronous active-high reset
//                tick                  one-cycle frame pulse
//                up/down/left/right    held direction keys
//                restart               leaves WIN / OVER
//                startblk..goalblk     region flags for the current box
//                xFlr/xCeil/yFlr/yCeil bounding box (registered floors)
//                lives                 remaining lives
//                dead/won/game_over    state indicators
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module player_ctrl
  import maze_pkg::*;
#(
  parameter int PLAYER_W   = 16,
  parameter int PLAYER_H   = 16,
  parameter int STEP       = 4,
  parameter int DEAD_CYC   = 25_000_000,
  parameter int START_X    = START_X_DEF,
  parameter int START_Y    = START_Y_DEF,
  parameter int TP_DST_X   = TP_DST_X_DEF,
  parameter int TP_DST_Y   = TP_DST_Y_DEF,
  parameter int LIVES_INIT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       restart,
  input  logic       startblk,
  input  logic       tpblks,
  input  logic       lavablks,
  input  logic       goalblk,
  output logic [9:0] xFlr,
  output logic [9:0] xCeil,
  output logic [9:0] yFlr,
  output logic [9:0] yCeil,
  output logic [1:0] lives,
  output logic       dead,
  output logic       won,
  output logic       game_over
);

  localparam int              CNT_W    = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYC - 1);
  localparam logic [9:0]      X_LIM    = 10'(SCREEN_W - PLAYER_W);
  localparam logic [9:0]      Y_LIM    = 10'(SCREEN_H - PLAYER_H);

  state_t           r_state, w_state_nxt;
  logic [9:0]       r_x, w_x_nxt, w_x_step;
  logic [9:0]       r_y, w_y_nxt, w_y_step;
  logic [1:0]       r_lives, w_lives_nxt;
  logic             r_armed, w_armed_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // The start region has no effect on this block
  logic w_unused_startblk;
  assign w_unused_startblk = startblk;

  // Only one axis moves per tick: vertical keys lock out horizontal ones
  logic w_x_en;
  assign w_x_en = ~(up | down);

  pos_axis #(.STEP(STEP)) u_axis_x (
    .i_flr   (r_x),
    .i_inc   (w_x_en & right & ~left),
    .i_dec   (w_x_en & left),
    .i_limit (X_LIM),
    .o_flr   (w_x_step)
  );

  pos_axis #(.STEP(STEP)) u_axis_y (
    .i_flr   (r_y),
    .i_inc   (down & ~up),
    .i_dec   (up),
    .i_limit (Y_LIM),
    .o_flr   (w_y_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_PLAY;
      r_x     <= 10'(START_X);
      r_y     <= 10'(START_Y);
      r_lives <= 2'(LIVES_INIT);
      r_armed <= 1'b1;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_x     <= w_x_nxt;
      r_y     <= w_y_nxt;
      r_lives <= w_lives_nxt;
      r_armed <= w_armed_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and datapath
  always_comb begin
    w_state_nxt = r_state;
    w_x_nxt     = r_x;
    w_y_nxt     = r_y;
    w_lives_nxt = r_lives;
    w_armed_nxt = r_armed;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_PLAY: begin
        // Leaving the pad re-arms it; standing on it keeps it disarmed
        if (!tpblks) w_armed_nxt = 1'b1;
        if (goalblk) begin
          w_state_nxt = ST_WIN;
        end else if (lavablks) begin
          if (r_lives > 2'd1) begin
            w_lives_nxt = r_lives - 2'd1;
            w_state_nxt = ST_DEAD;
            w_cnt_nxt   = '0;
          end else begin
            w_lives_nxt = 2'd0;
            w_state_nxt = ST_OVER;
          end
        end else if (tpblks && r_armed) begin
          w_x_nxt     = 10'(TP_DST_X);
          w_y_nxt     = 10'(TP_DST_Y);
          w_armed_nxt = 1'b0;
        end else if (tick) begin
          w_x_nxt = w_x_step;
          w_y_nxt = w_y_step;
        end
      end
      ST_DEAD: begin
        if (r_cnt == CNT_LAST) begin
          w_x_nxt     = 10'(START_X);
          w_y_nxt     = 10'(START_Y);
          w_armed_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PLAY;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin // ST_WIN, ST_OVER
        if (restart) begin
          w_x_nxt     = 10'(START_X);
          w_y_nxt     = 10'(START_Y);
          w_lives_nxt = 2'(LIVES_INIT);
          w_armed_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_PLAY;
        end
      end
    endcase
  end

  // Outputs depend only on registers
  always_comb begin
    dead      = (r_state == ST_DEAD);
    won       = (r_state == ST_WIN);
    game_over = (r_state == ST_OVER);
  end

  assign xFlr  = r_x;
  assign yFlr  = r_y;
  assign xCeil = r_x + 10'(PLAYER_W);
  assign yCeil = r_y + 10'(PLAYER_H);
  assign lives = r_lives;

endmodule : player_ctrl

`default_nettype wire

// File: tb/tb_player_ctrl.sv
// ============================================================================
//  Module      : tb_player_ctrl
//  Description : Self-checking bench for player_ctrl (DEAD_CYC shortened to 4)
//                with a direct check of the pos_axis clamp.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_player_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, tick, up, down, left, right, restart;
  logic       m_tp, m_lava, m_goal, use_model;
  logic       startblk, tpblks, lavablks, goalblk;
  logic [9:0] xFlr, xCeil, yFlr, yCeil;
  logic [1:0] lives;
  logic       dead, won, game_over;

  int total = 0;
  int bad   = 0;

  // Classifier model: lava pit covering x 0..32, y 210..240
  logic model_lava;
  assign model_lava = (xFlr < 10'd32) && (yFlr >= 10'd210) && (yFlr < 10'd240);

  assign startblk = 1'b0;
  assign tpblks   = use_model ? 1'b0       : m_tp;
  assign lavablks = use_model ? model_lava : m_lava;
  assign goalblk  = use_model ? 1'b0       : m_goal;

  player_ctrl #(.DEAD_CYC(4)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .up(up), .down(down), .left(left), .right(right), .restart(restart),
    .startblk(startblk), .tpblks(tpblks), .lavablks(lavablks), .goalblk(goalblk),
    .xFlr(xFlr), .xCeil(xCeil), .yFlr(yFlr), .yCeil(yCeil),
    .lives(lives), .dead(dead), .won(won), .game_over(game_over)
  );

  // Stand-alone axis for clamp corners unreachable on a 4-pixel grid
  logic [9:0] ax_flr, ax_lim, ax_out;
  logic       ax_inc, ax_dec;
  pos_axis #(.STEP(4)) u_ax (
    .i_flr(ax_flr), .i_inc(ax_inc), .i_dec(ax_dec), .i_limit(ax_lim), .o_flr(ax_out)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tick = 0; up = 0; down = 0; left = 0; right = 0; restart = 0;
    m_tp = 0; m_lava = 0; m_goal = 0;
  endtask

  task automatic check_state(input string tag, input int ex, input int ey, input int el,
                             input int ed, input int ew, input int eo);
    check({tag, " xFlr"},  int'(xFlr),  ex);
    check({tag, " yFlr"},  int'(yFlr),  ey);
    check({tag, " xCeil"}, int'(xCeil), ex + 16);
    check({tag, " yCeil"}, int'(yCeil), ey + 16);
    check({tag, " lives"}, int'(lives), el);
    check({tag, " dead"},  int'(dead),  ed);
    check({tag, " won"},   int'(won),   ew);
    check({tag, " over"},  int'(game_over), eo);
  endtask

  typedef struct {
    logic tk, u, d, l, r, tp, lava, goal, rs;
    int   ex, ey, el;
    logic ed, ew, eo;
  } vec_t;

  vec_t vecs[24];

  initial begin
    //          tk u d l r tp lv gl rs   x   y  l  d w o
    vecs[0]  = '{1,0,0,0,1,0,0,0,0,  12,  7, 3, 0,0,0};
    vecs[1]  = '{1,0,0,0,1,0,0,0,0,  16,  7, 3, 0,0,0};
    vecs[2]  = '{1,0,0,0,1,0,0,0,0,  20,  7, 3, 0,0,0};
    vecs[3]  = '{0,0,0,0,1,0,0,0,0,  20,  7, 3, 0,0,0}; // no tick, no move
    vecs[4]  = '{1,1,1,0,0,0,0,0,0,  20,  3, 3, 0,0,0}; // up beats down
    vecs[5]  = '{1,1,0,0,0,0,0,0,0,  20,  0, 3, 0,0,0}; // 3 < STEP clamps to 0
    vecs[6]  = '{1,0,1,0,0,0,0,0,0,  20,  4, 3, 0,0,0};
    vecs[7]  = '{1,0,0,1,1,0,0,0,0,  16,  4, 3, 0,0,0}; // left beats right
    vecs[8]  = '{1,1,0,1,0,0,0,0,0,  16,  0, 3, 0,0,0}; // only y moves
    vecs[9]  = '{1,0,0,0,1,1,0,0,0, 424, 97, 3, 0,0,0}; // teleport, tick dropped
    vecs[10] = '{0,0,0,0,0,1,0,0,0, 424, 97, 3, 0,0,0};
    vecs[11] = '{0,0,0,0,0,1,0,0,0, 424, 97, 3, 0,0,0};
    vecs[12] = '{1,0,0,0,1,0,0,0,0, 428, 97, 3, 0,0,0}; // off pad: re-arm
    vecs[13] = '{1,0,0,0,1,1,0,0,0, 424, 97, 3, 0,0,0}; // teleports again
    vecs[14] = '{1,0,0,1,0,1,0,0,0, 420, 97, 3, 0,0,0}; // disarmed pad: moves
    vecs[15] = '{1,0,0,0,1,0,1,1,0, 420, 97, 3, 0,1,0}; // goal beats lava
    vecs[16] = '{1,0,0,0,1,0,1,0,0, 420, 97, 3, 0,1,0}; // WIN ignores inputs
    vecs[17] = '{0,0,0,0,0,0,0,0,1,   8,  7, 3, 0,0,0}; // restart
    vecs[18] = '{0,0,0,0,0,0,1,0,0,   8,  7, 2, 1,0,0}; // lava, dead cycle 1
    vecs[19] = '{1,0,0,0,1,1,1,1,1,   8,  7, 2, 1,0,0}; // dead cycle 2
    vecs[20] = '{1,0,0,0,1,0,0,0,0,   8,  7, 2, 1,0,0}; // dead cycle 3
    vecs[21] = '{1,0,0,0,1,0,0,0,0,   8,  7, 2, 1,0,0}; // dead cycle 4
    vecs[22] = '{1,0,0,0,1,0,0,0,0,   8,  7, 2, 0,0,0}; // respawn, tick dropped
    vecs[23] = '{1,0,0,0,1,0,0,0,0,  12,  7, 2, 0,0,0};
  end

  initial begin
    int n;
    idle();
    use_model = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    check_state("reset", 8, 7, 3, 0, 0, 0);

    // Table-driven vectors, each applied for one clock
    for (int i = 0; i < 24; i++) begin
      tick = vecs[i].tk; up = vecs[i].u; down = vecs[i].d;
      left = vecs[i].l; right = vecs[i].r; restart = vecs[i].rs;
      m_tp = vecs[i].tp; m_lava = vecs[i].lava; m_goal = vecs[i].goal;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey, vecs[i].el,
                  int'(vecs[i].ed), int'(vecs[i].ew), int'(vecs[i].eo));
    end
    idle();

    // Walk down into the model lava pit; first lava y on the grid is 211
    use_model = 1;
    tick = 1; left = 1;
    step();
    left = 0; down = 1;
    n = 0;
    while (!dead && n < 80) begin step(); n++; end
    check("lava1 seen", int'(dead), 1);
    check("lava1 yFlr", int'(yFlr), 211);
    check("lava1 lives", int'(lives), 1);
    n = 0;
    while (dead && n < 10) begin
      n++;
      check("dead frozen y", int'(yFlr), 211);
      step();
    end
    check("dead length", n, 4);
    check_state("respawn", 8, 7, 1, 0, 0, 0);

    // Final life lost
    n = 0;
    while (!game_over && !dead && n < 80) begin step(); n++; end
    check_state("over", 8, 211, 0, 0, 0, 1);
    use_model = 0;
    up = 1; down = 0; m_goal = 1; m_tp = 1; m_lava = 1;
    for (int i = 0; i < 3; i++) step();
    check_state("over hold", 8, 211, 0, 0, 0, 1);
    idle();
    reset = 1;
    step();
    reset = 0;
    check_state("reset in OVER", 8, 7, 3, 0, 0, 0);

    // Teleport held for 10 cycles, then drop and reassert
    m_tp = 1;
    step();
    check_state("tp", 424, 97, 3, 0, 0, 0);
    for (int i = 0; i < 10; i++) step();
    check_state("tp held", 424, 97, 3, 0, 0, 0);
    m_tp = 0; tick = 1; down = 1;
    step();
    check_state("tp off", 424, 101, 3, 0, 0, 0);
    m_tp = 1; tick = 0; down = 0;
    step();
    check_state("tp again", 424, 97, 3, 0, 0, 0);
    idle();

    // Screen-edge clamps through the top level
    tick = 1; right = 1;
    for (int i = 0; i < 60; i++) step();
    check("clamp right xFlr", int'(xFlr), 624);
    check("clamp right xCeil", int'(xCeil), 640);
    right = 0; down = 1;
    for (int i = 0; i < 100; i++) step();
    check("clamp down yFlr", int'(yFlr), 464);
    check("clamp down yCeil", int'(yCeil), 480);
    idle();

    // Axis corners off the 4-pixel grid
    ax_flr = 10'd622; ax_inc = 1; ax_dec = 0; ax_lim = 10'd624; #1;
    check("axis 622 inc", int'(ax_out), 624);
    ax_flr = 10'd2; ax_inc = 0; ax_dec = 1; #1;
    check("axis 2 dec", int'(ax_out), 0);
    ax_flr = 10'd1021; ax_inc = 1; ax_dec = 0; ax_lim = 10'd1023; #1;
    check("axis no wrap", int'(ax_out), 1023);
    ax_flr = 10'd100; ax_inc = 1; ax_dec = 1; #1;
    check("axis dec wins", int'(ax_out), 96);
    ax_flr = 10'd100; ax_inc = 0; ax_dec = 0; #1;
    check("axis hold", int'(ax_out), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_player_ctrl

`default_nettype wire
